eccop_csr: RTL
==============

# eccop_csr

Control/status register responder for the ECC operation coprocessor. Sits on the control slave port of the coprocessor interconnect and answers its Avalon-MM read/write transactions with a single wait state. Holds the engine start address and control bits, tracks engine state, counts busy cycles and raises a level interrupt on completion or error.

## Interface
Parameters:
- aw, 32, width of the address bus (word index; only [13:0] decoded)
- dw, 4, data bus width in bytes; only 4 is supported
- ID_VALUE, 32'hECC0_0100, constant returned by the ID register

Ports:
- clk  in  1  clock; all logic on rising edge
- sreset  in  1  synchronous active-high reset
- cmd_address  in  aw  word address from interconnect
- cmd_byteenable  in  dw  byte lane enables for writes
- cmd_writedata  in  32  write data
- cmd_write  in  1  write request, held until waitrequest low
- cmd_read  in  1  read request, held until waitrequest low
- cmd_readdata  out  32  read data, valid in the cycle cmd_waitrequest is low
- cmd_waitrequest  out  1  low for exactly one cycle per accepted transfer
- eng_start  out  1  one-cycle start pulse to engine
- eng_abort  out  1  one-cycle abort pulse to engine
- eng_pc  out  14  code memory start address for engine
- eng_done  in  1  one-cycle pulse: engine finished (normal or aborted)
- eng_error  in  1  qualifies eng_done: operation failed
- irq  out  1  registered level interrupt

## Operation
- Bus FSM states: IDLE, ACK. IDLE: waitrequest=1; if cmd_read|cmd_write, go ACK. ACK: waitrequest=0, readdata driven; always return to IDLE.
- Write commit at end of ACK cycle; only lanes with byteenable set are updated.
- Register map (word index):
  - 0 CTRL: bit0 START (W1 pulse, reads 0), bit1 IRQ_EN (RW), bit2 ABORT (W1 pulse, reads 0).
  - 1 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERROR (W1C), bit3 START_REJ (W1C).
  - 2 PC: bits[13:0] RW, drives eng_pc; upper bits read 0.
  - 3 CYCLES: RO busy-cycle counter.
  - 4 ID: RO ID_VALUE.
  - other indices: read 0, write ignored, still acknowledged.
- START written while BUSY=0: eng_start pulses next cycle, BUSY set, CYCLES cleared. While BUSY=1: no pulse, START_REJ set.
- ABORT while BUSY=1: eng_abort pulses; ignored when idle.
- eng_done: BUSY cleared, DONE set, ERROR set if eng_error.
- Hardware set beats software W1C in the same cycle.
- irq = IRQ_EN & (DONE | ERROR), registered.
- Reset values: all registers 0, waitrequest=1, readdata=0, eng_start=0, eng_abort=0, eng_pc=0, irq=0, FSM IDLE.

## Timing
- Request seen at cycle N; waitrequest low at N+1; interconnect drops request at N+2, FSM back in IDLE at N+2 (no double acknowledge).
- Throughput: one transfer per 2 cycles.
- eng_start/eng_abort asserted the cycle after ACK, width one cycle.
- CYCLES increments every cycle BUSY=1, saturates at 32'hFFFF_FFFF.
- irq follows status change by one cycle.
- sreset mid-transaction: returns to IDLE, waitrequest=1; interconnect is reset with the same signal.
- Read of STATUS in the same cycle eng_done arrives returns pre-update value.

## Configuration
- ECCOP_CSR_CYCLE_COUNTER_EN defined: CYCLES counter implemented as above.
- Not defined: no counter logic; word 3 reads 0, writes ignored.

## Test plan
- Reset then read ID (addr 4) -> waitrequest low exactly one cycle after request, readdata=32'hECC0_0100; all outputs at reset values.
- Write PC=0x1234 with byteenable 4'b0001, then 4'b0010 -> eng_pc=0x34 after first, 0x1234 after second; readback 0x0000_1234.
- Write CTRL=0x3 -> eng_start one-cycle pulse, STATUS=0x1; 50 cycles later eng_done -> STATUS=0x2, irq=1 one cycle later, CYCLES=50 (macro on) or 0 (off).
- Write START while busy -> no eng_start, STATUS bit3=1; W1C 0x8 clears it.
- eng_done with eng_error in same cycle as W1C write 0x6 to STATUS -> DONE and ERROR remain 1.
- Read/write addr 7 -> acknowledged, readdata=0, no register change; sreset asserted during ACK -> waitrequest=1 next cycle, all registers 0.

Source files
------------

// File: rtl/eccop_csr.sv
// eccop_csr: Avalon-MM control/status register responder for the ECC coprocessor (one wait state).
// Define ECCOP_CSR_CYCLE_COUNTER_EN to implement the CYCLES busy-cycle counter at word 3.
module eccop_csr #(
    parameter int          aw       = 32,
    parameter int          dw       = 4,
    parameter logic [31:0] ID_VALUE = 32'hECC0_0100
) (
    input  logic          clk,
    input  logic          sreset,
    input  logic [aw-1:0] cmd_address,
    input  logic [dw-1:0] cmd_byteenable,
    input  logic [31:0]   cmd_writedata,
    input  logic          cmd_write,
    input  logic          cmd_read,
    output logic [31:0]   cmd_readdata,
    output logic          cmd_waitrequest,
    output logic          eng_start,
    output logic          eng_abort,
    output logic [13:0]   eng_pc,
    input  logic          eng_done,
    input  logic          eng_error,
    output logic          irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state;
    logic        irq_en;
    logic        busy;
    logic        done_flag;
    logic        error_flag;
    logic        start_rej;
    logic [13:0] word;
    logic        commit;
    logic        ctrl_wr;
    logic        status_wr;
    logic        pc_wr;
    logic        start_ok;
    logic        start_rejected;
    logic        abort_ok;
    logic [31:0] cycles_rd;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign word           = cmd_address[13:0];
    // The request is still held during ACK, so writes commit from the live bus at the end of ACK.
    assign commit         = (state == ACK) && cmd_write;
    assign ctrl_wr        = commit && (word == 14'd0) && cmd_byteenable[0];
    assign status_wr      = commit && (word == 14'd1) && cmd_byteenable[0];
    assign pc_wr          = commit && (word == 14'd2);
    assign start_ok       = ctrl_wr && cmd_writedata[0] && !busy;
    assign start_rejected = ctrl_wr && cmd_writedata[0] && busy;
    assign abort_ok       = ctrl_wr && cmd_writedata[2] && busy;
    assign unused_bits    = ^{cmd_address[aw-1:14], cmd_byteenable[dw-1:2], cmd_writedata[31:14]};

    always_comb begin
        rd_mux = '0;
        case (word)
            14'd0:   rd_mux = {29'd0, 1'b0, irq_en, 1'b0};
            14'd1:   rd_mux = {28'd0, start_rej, error_flag, done_flag, busy};
            14'd2:   rd_mux = {18'd0, eng_pc};
            14'd3:   rd_mux = cycles_rd;
            14'd4:   rd_mux = ID_VALUE;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state           <= IDLE;
            cmd_waitrequest <= 1'b1;
            cmd_readdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_read || cmd_write) begin
                        state           <= ACK;
                        cmd_waitrequest <= 1'b0;
                        cmd_readdata    <= cmd_read ? rd_mux : '0;
                    end else begin
                        cmd_waitrequest <= 1'b1;
                        cmd_readdata    <= '0;
                    end
                end
                ACK: begin
                    state           <= IDLE;
                    cmd_waitrequest <= 1'b1;
                    cmd_readdata    <= '0;
                end
                default: begin
                    state           <= IDLE;
                    cmd_waitrequest <= 1'b1;
                    cmd_readdata    <= '0;
                end
            endcase
        end
    end

    // Hardware status sets are OR-ed in after the W1C mask so they win over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (sreset) begin
            eng_start  <= 1'b0;
            eng_abort  <= 1'b0;
            eng_pc     <= '0;
            irq_en     <= 1'b0;
            busy       <= 1'b0;
            done_flag  <= 1'b0;
            error_flag <= 1'b0;
            start_rej  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            eng_start <= start_ok;
            eng_abort <= abort_ok;
            if (ctrl_wr) begin
                irq_en <= cmd_writedata[1];
            end
            if (pc_wr && cmd_byteenable[0]) begin
                eng_pc[7:0] <= cmd_writedata[7:0];
            end
            if (pc_wr && cmd_byteenable[1]) begin
                eng_pc[13:8] <= cmd_writedata[13:8];
            end
            if (start_ok) begin
                busy <= 1'b1;
            end else if (eng_done) begin
                busy <= 1'b0;
            end
            done_flag  <= eng_done | (done_flag & ~(status_wr & cmd_writedata[1]));
            error_flag <= (eng_done & eng_error) | (error_flag & ~(status_wr & cmd_writedata[2]));
            start_rej  <= start_rejected | (start_rej & ~(status_wr & cmd_writedata[3]));
            irq        <= irq_en & (done_flag | error_flag);
        end
    end

`ifdef ECCOP_CSR_CYCLE_COUNTER_EN
    logic [31:0] cycles;

    always_ff @(posedge clk) begin
        if (sreset) begin
            cycles <= '0;
        end else if (start_ok) begin
            cycles <= '0;
        end else if (busy && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end

    assign cycles_rd = cycles;
`else
    assign cycles_rd = '0;
`endif

endmodule
